// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin_to_bcd_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Shown on every digit when the input cannot be represented.
    localparam logic [3:0] BCD_OVF_NIBBLE = 4'hE;

    // Largest value representable in the given number of decimal digits.
    function automatic int unsigned max_val(input int unsigned digits);
        int unsigned v;
        v = 1;
        for (int unsigned i = 0; i < digits; i++) begin
            v = v * 10;
        end
        return v - 1;
    endfunction

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Start/busy/done handshake plus data for the BCD converter.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
);
    logic                  start;
    logic [BIN_W-1:0]      bin_in;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (output start, bin_in, input busy, done, overflow, bcd_out);
    modport slave  (input start, bin_in, output busy, done, overflow, bcd_out);
endinterface

// File: rtl/bcd_dabble_cell.sv
// One double-dabble correction: a BCD nibble of 5 or more gets +3 before the shift.
module bcd_dabble_cell (
    input  logic [3:0] d_in,
    output logic [3:0] d_out
);
    // Pre-shift correction so the doubled nibble carries into the next digit.
    always_comb begin
        d_out = (d_in >= 4'd5) ? d_in + 4'd3 : d_in;
    end
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, BIN_W shifts per value.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic              clk,
    input  logic              rst,
    bin_to_bcd_seq_if.slave   bus
);
    localparam int          SW      = 4 * DIGITS + 4;  // one spare nibble absorbs the top carry
    localparam int          CW      = $clog2(BIN_W + 1);
    localparam int unsigned MAX_VAL = max_val(DIGITS);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [BIN_W-1:0]    sh_q, sh_d;
    logic [SW-1:0]       scr_q, scr_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overflow_q, overflow_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d;

    logic [SW-1:0]       scr_adj;
    logic [SW-1:0]       scr_nxt;

    // Correct every scratch nibble in parallel ahead of the shift.
    for (genvar g = 0; g < DIGITS + 1; g++) begin : g_cell
        bcd_dabble_cell u_cell (
            .d_in  (scr_q[4*g +: 4]),
            .d_out (scr_adj[4*g +: 4])
        );
    end

    assign scr_nxt = {scr_adj[SW-2:0], sh_q[BIN_W-1]};

    // Next-state and output logic; results load on the last shift so they are valid with done.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sh_d       = sh_q;
        scr_d      = scr_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overflow_d = overflow_q;
        bcd_d      = bcd_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    sh_d       = bus.bin_in;
                    scr_d      = '0;
                    cnt_d      = '0;
                    ovf_pend_d = 32'(bus.bin_in) > MAX_VAL;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scr_d = scr_nxt;
                sh_d  = {sh_q[BIN_W-2:0], 1'b0};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(BIN_W - 1)) begin
                    state_d    = ST_DONE;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    overflow_d = ovf_pend_q;
                    bcd_d      = ovf_pend_q ? {DIGITS{BCD_OVF_NIBBLE}}
                                            : scr_nxt[4*DIGITS-1:0];
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            sh_q       <= '0;
            scr_q      <= '0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
            bcd_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sh_q       <= sh_d;
            scr_q      <= scr_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
            bcd_q      <= bcd_d;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.overflow = overflow_q;
    assign bus.bcd_out  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: timing/arithmetic reference model plus directed vectors.
module tb_bin_to_bcd_seq;
    localparam int BIN_W  = 14;
    localparam int DIGITS = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    logic chk_en = 1'b0;

    bin_to_bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Decimal digits by plain division; out-of-range values show all E.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int p;
        if (v > 9999) return 16'hEEEE;
        r = '0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Reference model: tracks cycles since the accepted start.
    logic        m_act = 1'b0;
    int          m_t   = 0;
    int          m_val = 0;
    logic [15:0] m_bcd = '0;
    logic        m_ovf = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_act = 1'b0;
            m_t   = 0;
            m_bcd = '0;
            m_ovf = 1'b0;
        end else if (!m_act) begin
            if (bus.start) begin
                m_act = 1'b1;
                m_t   = 0;
                m_val = int'(bus.bin_in);
            end
        end else begin
            m_t++;
            if (m_t == BIN_W) begin
                m_bcd = ref_bcd(m_val);
                m_ovf = (m_val > 9999);
            end
            if (m_t == BIN_W + 1) m_act = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy",  32'(bus.busy),     32'(m_act && m_t < BIN_W));
            chk("cyc_done",  32'(bus.done),     32'(m_act && m_t == BIN_W));
            chk("cyc_ovf",   32'(bus.overflow), 32'(m_ovf));
            chk("cyc_bcd",   32'(bus.bcd_out),  32'(m_bcd));
        end
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            bus.start = 1'b0;
            n++;
        end while (!bus.done && n < 40);
        if (!bus.done) chk("done_timeout", 32'(n), 32'(0));
    endtask

    task automatic convert(input int v, input logic [15:0] eb, input logic eo, input string nm);
        int n;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 14'(v);
        wait_done(n);
        chk({nm, "_lat"}, 32'(n), 32'd15);
        chk({nm, "_bcd"}, 32'(bus.bcd_out), 32'(eb));
        chk({nm, "_ovf"}, 32'(bus.overflow), 32'(eo));
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n, ndone;
        logic [15:0] got;
        logic [15:0] seq_b [4];
        int          seq_v [4];
        bus.start  = 1'b0;
        bus.bin_in = '0;
        #1 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ovf",  32'(bus.overflow), 32'd0);
        chk("rst_bcd",  32'(bus.bcd_out), 32'd0);
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);

        // 1/2: zero, ordinary value, largest in-range value
        convert(0,    16'h0000, 1'b0, "zero");
        convert(1234, 16'h1234, 1'b0, "v1234");
        convert(9999, 16'h9999, 1'b0, "v9999");

        // 3: overflow, then cleared by an in-range value
        convert(10000, 16'hEEEE, 1'b1, "v10000");
        convert(42,    16'h0042, 1'b0, "v42");

        // 4: start while busy is ignored
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 14'd1234;
        ndone = 0;
        got   = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) bus.start = 1'b0;
            if (i == 5) begin
                bus.start  = 1'b1;
                bus.bin_in = 14'd5678;
            end
            if (i == 6) bus.start = 1'b0;
            if (bus.done) begin
                ndone++;
                got = bus.bcd_out;
            end
        end
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_bcd",   32'(got),   32'h1234);

        // 5: reset in the middle of a conversion
        convert(777, 16'h0777, 1'b0, "v777");
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 14'd300;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_bcd",  32'(bus.bcd_out), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("mid_rst_nodone", 32'(ndone), 32'd0);
        convert(555, 16'h0555, 1'b0, "after_rst");

        // 6: start held high with alternating values
        seq_v[0] = 7;  seq_v[1] = 16383; seq_v[2] = 7;  seq_v[3] = 16383;
        seq_b[0] = 16'h0007; seq_b[1] = 16'hEEEE; seq_b[2] = 16'h0007; seq_b[3] = 16'hEEEE;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bin_in = 14'(seq_v[0]);
        @(negedge clk);
        bus.bin_in = 14'(seq_v[1]);
        n = 1;
        for (int k = 0; k < 4; k++) begin
            int m;
            m = 0;
            while (!bus.done && m < 40) begin
                @(negedge clk);
                m++;
            end
            if (!bus.done) chk("b2b_timeout", 32'(m), 32'd0);
            chk($sformatf("b2b_period%0d", k), 32'(n + m), 32'(k == 0 ? 15 : 16));
            chk($sformatf("b2b_bcd%0d", k), 32'(bus.bcd_out), 32'(seq_b[k]));
            chk($sformatf("b2b_ovf%0d", k), 32'(bus.overflow), 32'(seq_v[k] > 9999));
            repeat (2) @(negedge clk);
            n = 2;
            if (k + 2 < 4) bus.bin_in = 14'(seq_v[k+2]);
        end
        bus.start = 1'b0;
        repeat (20) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
